layer_ram_cache: RTL and testbench
==================================

# layer_ram_cache

Small fully associative read cache between the layer RAM front end and the SDRAM controller. Holds up to CACHE_DEPTH 16-bit words, each tagged by pipeline layer number and SDRAM word address, so repeated pipeline reads of nearby pixels avoid an SDRAM access. Lookup is combinational. Fill happens one word per clock from SDRAM read data.

## Interface
- CACHE_DEPTH, default 4: number of entries. Any integer ≥1, not restricted to powers of two.
- clk_n  input  1: clock; all state changes on the rising edge.
- rst  input  1: reset, asynchronous, active-low; invalidates all entries.
- write_en  input  1: fill request; writes data_i under tag {layer, addr_words} at the next edge.
- layer  input  6: layer tag for lookup and fill.
- addr_words  input  24: SDRAM word address for lookup and fill.
- data_i  input  16: fill data from SDRAM.
- data_o  output  16: cached word on a hit; 16'h0000 on a miss.
- data_o_valid  output  1: 1 when {layer, addr_words} matches a valid entry.

## Operation
- Storage per entry: valid (1), layer tag (6), address tag (24), data (16).
- Replacement pointer: ptr, width max(1, $clog2(CACHE_DEPTH)).
- Lookup is combinational and fully associative. An entry hits when it is valid, its layer tag equals layer, and its address tag equals addr_words.
- Outputs: data_o_valid = OR of all hits. data_o = data of the hitting entry, else 0.
- Tags are unique, so at most one entry can hit.
- Fill with write_en=1 and a hit on entry i: entry i's data is overwritten with data_i. Tags, valid and ptr are unchanged.
- Fill with write_en=1 and a miss: entry[ptr] gets valid=1, tags {layer, addr_words}, data=data_i.
  - ptr then advances: ptr = (ptr == CACHE_DEPTH-1) ? 0 : ptr+1.
  - This is FIFO replacement; a valid entry at ptr is evicted silently.
- write_en=0: no state change.
- Reset (rst=0): all valid=0 and ptr=0 immediately. Data and tag contents are don't-care.
- Reset asserted during a write: reset wins; no entry is written.
- Reset is also used as a flush by the front end. Holding rst low for any duration leaves the cache empty once released.

## Timing
- Lookup latency 0: data_o and data_o_valid follow the inputs combinationally.
- Fill latency 1: a word written at edge N is visible to lookups after edge N.
- Without bypass, lookup during the write cycle reflects pre-write contents.
- Back-to-back fills: one per cycle, no stall, no busy output.
- Reset values: data_o_valid=0 and data_o=0 for any input while rst=0 and after release until the first fill.
- No handshake: the block is always ready.

## Configuration
- LAYER_RAM_CACHE_BYPASS_EN defined:
  - When write_en=1, lookup tag {layer, addr_words} is the same as the fill tag.
  - In that case data_o=data_i and data_o_valid=1 combinationally, in the same cycle.
  - This applies whether or not the tag already exists.
- LAYER_RAM_CACHE_BYPASS_EN undefined: the lookup reflects stored contents only; a written word becomes visible the cycle after the write.
- Storage and replacement behaviour are identical either way.

## Test plan
- Reset then lookup layer=3, addr=0x000100 -> data_o_valid=0, data_o=0x0000.
- Fill layer=3, addrs 0x100..0x103 with 0xA000..0xA003 on 4 consecutive cycles, then look up each -> hit, matching data. Look up 0x104 -> miss.
- With depth 4 full as above, fill layer=3 addr=0x104 data 0xB004 -> 0x104 hits 0xB004, 0x100 misses (evicted), 0x101 still hits 0xA001.
- Fill layer=3 addr=0x101 data 0xC001 (already present), then a new tag -> 0x101 returns 0xC001. The new tag replaces the entry at ptr (0x101's entry is not reused twice). ptr did not advance on the update.
- Same addr 0x200 filled for layer=1 (0x1111) and layer=2 (0x2222) -> each layer returns its own word; layer=0 at 0x200 misses.
- Assert rst mid-sequence with write_en=1 -> all lookups miss after release. With bypass: write_en=1, layer=5, addr=0x300, data 0x5555 -> data_o=0x5555, valid=1 in the same cycle. Without bypass: valid=0 in that cycle, 1 the next.

Source files
------------

// File: rtl/layer_ram_cache.sv
// Fully associative FIFO-replacement read cache between the layer RAM front end and SDRAM.
// Optional macro LAYER_RAM_CACHE_BYPASS_EN forwards fill data to the lookup outputs in the write cycle.
module layer_ram_cache #(
  parameter int CACHE_DEPTH = 4
) (
  input  logic        clk_n,
  input  logic        rst,
  input  logic        write_en,
  input  logic [5:0]  layer,
  input  logic [23:0] addr_words,
  input  logic [15:0] data_i,
  output logic [15:0] data_o,
  output logic        data_o_valid
);

  localparam int PTR_W = (CACHE_DEPTH > 1) ? $clog2(CACHE_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(CACHE_DEPTH - 1);

  logic [CACHE_DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [5:0]             layer_tag_q [CACHE_DEPTH];
  logic [5:0]             layer_tag_d [CACHE_DEPTH];
  logic [23:0]            addr_tag_q  [CACHE_DEPTH];
  logic [23:0]            addr_tag_d  [CACHE_DEPTH];
  logic [15:0]            data_q      [CACHE_DEPTH];
  logic [15:0]            data_d      [CACHE_DEPTH];

  logic [CACHE_DEPTH-1:0] hit;
  logic                   any_hit;
  logic [15:0]            hit_data;

  genvar gi;
  generate
    for (gi = 0; gi < CACHE_DEPTH; gi++) begin : g_match
      assign hit[gi] = valid_q[gi] && (layer_tag_q[gi] == layer) && (addr_tag_q[gi] == addr_words);
    end
  endgenerate

  // Tags are unique, so OR-ing the masked data words yields the single hit's data.
  always_comb begin
    hit_data = '0;
    for (int i = 0; i < CACHE_DEPTH; i++) begin
      if (hit[i]) begin
        hit_data = hit_data | data_q[i];
      end
    end
  end

  assign any_hit = |hit;

`ifdef LAYER_RAM_CACHE_BYPASS_EN
  // Forwarding is suppressed while reset holds the cache empty.
  always_comb begin
    data_o_valid = any_hit;
    data_o       = hit_data;
    if (write_en && rst) begin
      data_o_valid = 1'b1;
      data_o       = data_i;
    end
  end
`else
  always_comb begin
    data_o_valid = any_hit;
    data_o       = hit_data;
  end
`endif

  always_comb begin
    valid_d     = valid_q;
    ptr_d       = ptr_q;
    layer_tag_d = layer_tag_q;
    addr_tag_d  = addr_tag_q;
    data_d      = data_q;
    if (write_en) begin
      if (any_hit) begin
        for (int i = 0; i < CACHE_DEPTH; i++) begin
          if (hit[i]) begin
            data_d[i] = data_i;
          end
        end
      end else begin
        valid_d[ptr_q]     = 1'b1;
        layer_tag_d[ptr_q] = layer;
        addr_tag_d[ptr_q]  = addr_words;
        data_d[ptr_q]      = data_i;
        ptr_d              = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_n or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  // Tag and data contents are meaningless while their valid bit is clear, so they carry no reset.
  always_ff @(posedge clk_n) begin
    layer_tag_q <= layer_tag_d;
    addr_tag_q  <= addr_tag_d;
    data_q      <= data_d;
  end

endmodule

// File: tb/tb_layer_ram_cache.sv
// Self-checking bench for layer_ram_cache: directed vector table, reset/bypass sequences,
// and randomized traffic against a keyed-map plus insertion-order-queue reference model.
module tb_layer_ram_cache;

  localparam int DEPTH = 4;
`ifdef LAYER_RAM_CACHE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk_n = 1'b0;
  logic        rst = 1'b0;
  logic        write_en = 1'b0;
  logic [5:0]  layer = '0;
  logic [23:0] addr_words = '0;
  logic [15:0] data_i = '0;
  logic [15:0] data_o;
  logic        data_o_valid;

  int checks = 0;
  int errors = 0;

  layer_ram_cache #(.CACHE_DEPTH(DEPTH)) dut (
    .clk_n(clk_n),
    .rst(rst),
    .write_en(write_en),
    .layer(layer),
    .addr_words(addr_words),
    .data_i(data_i),
    .data_o(data_o),
    .data_o_valid(data_o_valid)
  );

  always #5 clk_n = ~clk_n;

  typedef struct {
    logic        we;
    logic [5:0]  lyr;
    logic [23:0] adr;
    logic [15:0] din;
    logic        ev;
    logic [15:0] ed;
  } vec_t;

  vec_t vecs[27];

  // Reference model: tag -> word, plus the order in which tags were first inserted.
  logic [15:0] mdl_data [logic [29:0]];
  logic [29:0] mdl_order[$];

  task automatic check(input string name, input logic v_act, input logic [15:0] d_act,
                       input logic v_exp, input logic [15:0] d_exp, input bit verbose);
    checks++;
    if (v_act !== v_exp || d_act !== d_exp) begin
      errors++;
      $display("FAIL %s: got valid=%0b data=%h, expected valid=%0b data=%h",
               name, v_act, d_act, v_exp, d_exp);
    end else if (verbose) begin
      $display("ok   %s: valid=%0b data=%h", name, v_act, d_act);
    end
  endtask

  task automatic step();
    @(posedge clk_n);
    #1;
  endtask

  task automatic drive(input logic we, input logic [5:0] l, input logic [23:0] a, input logic [15:0] d);
    write_en   = we;
    layer      = l;
    addr_words = a;
    data_i     = d;
  endtask

  task automatic mdl_lookup(input logic [5:0] l, input logic [23:0] a, output logic v, output logic [15:0] d);
    logic [29:0] k;
    k = {l, a};
    v = mdl_data.exists(k);
    d = v ? mdl_data[k] : 16'h0000;
  endtask

  task automatic mdl_fill(input logic [5:0] l, input logic [23:0] a, input logic [15:0] d);
    logic [29:0] k;
    logic [29:0] old;
    k = {l, a};
    if (!mdl_data.exists(k)) begin
      if (mdl_order.size() == DEPTH) begin
        old = mdl_order.pop_front();
        mdl_data.delete(old);
      end
      mdl_order.push_back(k);
    end
    mdl_data[k] = d;
  endtask

  initial begin
    logic        ev;
    logic [15:0] ed;

    // Reset held from time 0: outputs must stay empty for any input.
    drive(1'b0, 6'd3, 24'h000100, 16'h1234);
    #3;
    check("reset_lookup", data_o_valid, data_o, 1'b0, 16'h0000, 1'b1);
    drive(1'b1, 6'd3, 24'h000100, 16'h1234);
    #1;
    check("reset_write_in", data_o_valid, data_o, 1'b0, 16'h0000, 1'b1);
    step();
    step();
    drive(1'b0, 6'd3, 24'h000100, 16'h0000);
    rst = 1'b1;
    #1;
    check("post_reset_lookup", data_o_valid, data_o, 1'b0, 16'h0000, 1'b1);

    vecs[0]  = '{1'b0, 6'd3, 24'h000100, 16'h0000, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 6'd3, 24'h000100, 16'hA000, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 6'd3, 24'h000101, 16'hA001, 1'b0, 16'h0000};
    vecs[3]  = '{1'b1, 6'd3, 24'h000102, 16'hA002, 1'b0, 16'h0000};
    vecs[4]  = '{1'b1, 6'd3, 24'h000103, 16'hA003, 1'b0, 16'h0000};
    vecs[5]  = '{1'b0, 6'd3, 24'h000100, 16'h0000, 1'b1, 16'hA000};
    vecs[6]  = '{1'b0, 6'd3, 24'h000101, 16'h0000, 1'b1, 16'hA001};
    vecs[7]  = '{1'b0, 6'd3, 24'h000102, 16'h0000, 1'b1, 16'hA002};
    vecs[8]  = '{1'b0, 6'd3, 24'h000103, 16'h0000, 1'b1, 16'hA003};
    vecs[9]  = '{1'b0, 6'd3, 24'h000104, 16'h0000, 1'b0, 16'h0000};
    vecs[10] = '{1'b1, 6'd3, 24'h000104, 16'hB004, 1'b0, 16'h0000};
    vecs[11] = '{1'b0, 6'd3, 24'h000104, 16'h0000, 1'b1, 16'hB004};
    vecs[12] = '{1'b0, 6'd3, 24'h000100, 16'h0000, 1'b0, 16'h0000};
    vecs[13] = '{1'b0, 6'd3, 24'h000101, 16'h0000, 1'b1, 16'hA001};
    vecs[14] = '{1'b1, 6'd3, 24'h000101, 16'hC001, 1'b1, 16'hA001};
    vecs[15] = '{1'b0, 6'd3, 24'h000101, 16'h0000, 1'b1, 16'hC001};
    // 0x101 is now the oldest insertion, so the next new tag evicts it, not 0x102.
    vecs[16] = '{1'b1, 6'd3, 24'h000105, 16'hD005, 1'b0, 16'h0000};
    vecs[17] = '{1'b0, 6'd3, 24'h000101, 16'h0000, 1'b0, 16'h0000};
    vecs[18] = '{1'b0, 6'd3, 24'h000102, 16'h0000, 1'b1, 16'hA002};
    vecs[19] = '{1'b0, 6'd3, 24'h000105, 16'h0000, 1'b1, 16'hD005};
    vecs[20] = '{1'b1, 6'd1, 24'h000200, 16'h1111, 1'b0, 16'h0000};
    vecs[21] = '{1'b1, 6'd2, 24'h000200, 16'h2222, 1'b0, 16'h0000};
    vecs[22] = '{1'b0, 6'd1, 24'h000200, 16'h0000, 1'b1, 16'h1111};
    vecs[23] = '{1'b0, 6'd2, 24'h000200, 16'h0000, 1'b1, 16'h2222};
    vecs[24] = '{1'b0, 6'd0, 24'h000200, 16'h0000, 1'b0, 16'h0000};
    vecs[25] = '{1'b0, 6'd3, 24'h000103, 16'h0000, 1'b0, 16'h0000};
    vecs[26] = '{1'b0, 6'd3, 24'h000104, 16'h0000, 1'b1, 16'hB004};

    for (int i = 0; i < 27; i++) begin
      drive(vecs[i].we, vecs[i].lyr, vecs[i].adr, vecs[i].din);
      #1;
      ev = vecs[i].ev;
      ed = vecs[i].ed;
      if (BYPASS && vecs[i].we) begin
        ev = 1'b1;
        ed = vecs[i].din;
      end
      check($sformatf("vec%0d l=%0d a=%h", i, vecs[i].lyr, vecs[i].adr), data_o_valid, data_o, ev, ed, 1'b1);
      step();
    end

    // Reset asserted mid-cycle during a write, held across two edges with write_en still high.
    drive(1'b1, 6'd7, 24'h000777, 16'h7777);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_write", data_o_valid, data_o, 1'b0, 16'h0000, 1'b1);
    step();
    step();
    rst = 1'b1;
    drive(1'b0, 6'd7, 24'h000777, 16'h0000);
    #1;
    check("flush_written_tag", data_o_valid, data_o, 1'b0, 16'h0000, 1'b1);
    drive(1'b0, 6'd3, 24'h000104, 16'h0000);
    #1;
    check("flush_0x104", data_o_valid, data_o, 1'b0, 16'h0000, 1'b1);
    drive(1'b0, 6'd2, 24'h000200, 16'h0000);
    #1;
    check("flush_l2_0x200", data_o_valid, data_o, 1'b0, 16'h0000, 1'b1);

    // Same-cycle visibility of a fill depends on the bypass build.
    drive(1'b1, 6'd5, 24'h000300, 16'h5555);
    #1;
    check("fill_cycle_0x300", data_o_valid, data_o, BYPASS, BYPASS ? 16'h5555 : 16'h0000, 1'b1);
    step();
    drive(1'b0, 6'd5, 24'h000300, 16'h0000);
    #1;
    check("next_cycle_0x300", data_o_valid, data_o, 1'b1, 16'h5555, 1'b1);

    // Randomized traffic on a small tag space so hits, updates and evictions all occur.
    rst = 1'b0;
    #1;
    mdl_data.delete();
    mdl_order.delete();
    step();
    rst = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b0;
        #1;
        check($sformatf("rnd%0d_rst", n), data_o_valid, data_o, 1'b0, 16'h0000, 1'b0);
        mdl_data.delete();
        mdl_order.delete();
        step();
        rst = 1'b1;
      end
      drive(1'($urandom_range(0, 1)), 6'($urandom_range(0, 2)), 24'($urandom_range(0, 5)), 16'($urandom));
      #1;
      mdl_lookup(layer, addr_words, ev, ed);
      if (BYPASS && write_en) begin
        ev = 1'b1;
        ed = data_i;
      end
      check($sformatf("rnd%0d we=%0b l=%0d a=%h", n, write_en, layer, addr_words),
            data_o_valid, data_o, ev, ed, 1'b0);
      if (write_en) begin
        mdl_fill(layer, addr_words, data_i);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
